instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches under a credit limit,
// buffers in-order responses with their PCs, and flushes on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_pc_d [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_data_d [DEPTH];

  logic          req_fire;
  logic          rsp_accept;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] out_after_rsp;
  logic [CW:0]   drop_sum;
  logic [31:0]   redirect_aligned;

  // Buffered entries count against the same credit as in-flight requests,
  // which is what keeps the FIFO from ever overflowing.
  assign credit_used      = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid   = rst_n && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr    = fetch_pc_q;
  assign req_fire         = imem_req_valid && imem_req_ready;

  assign rsp_accept       = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_drop         = rsp_accept && (drop_q != '0);
  assign push             = rsp_accept && !rsp_drop && !redirect_valid;

  assign inst_valid       = (count_q != '0) && !redirect_valid;
  assign inst_data        = fifo_data_q[rd_ptr_q];
  assign inst_pc          = fifo_pc_q[rd_ptr_q];
  assign pop              = inst_valid && inst_ready;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign out_after_rsp    = outstanding_q - CW'(rsp_accept);
  assign drop_sum         = {1'b0, out_after_rsp} + {1'b0, drop_q};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_accept);
    drop_d        = drop_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_data_d   = fifo_data_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Every response still in flight after this cycle belongs to the old path.
      drop_d     = (drop_sum > {1'b0, out_after_rsp}) ? out_after_rsp : drop_sum[CW-1:0];
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        fifo_pc_d[wr_ptr_q]   = rsp_pc_q;
        fifo_data_d[wr_ptr_q] = imem_rsp_data;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        rsp_pc_d              = rsp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_data_q   <= fifo_data_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: an in-order memory model answers
// fetches, and a monitor compares every delivered instruction to the queue.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic        mem_hold;
  int          vectors = 0;
  int          miscompares = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_inst(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, data: mem_word(pc)});
  endtask

  task automatic apply_stimulus_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check_output(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Memory: responses in request order, one cycle after the request, unless held.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
      @(posedge clk);
      #3;
      if (!mem_hold && pend_q.size() != 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_inst: got pc %h data %h, expected none", inst_pc, inst_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("inst_pc", inst_pc, e.pc);
        check_output("inst_data", inst_data, e.data);
      end
    end
  end

  initial begin
    int fires;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    mem_hold       = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_output("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_output("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_output("rst_inst_data", inst_data, 32'd0);
    check_output("rst_inst_pc", inst_pc, 32'd0);
    check_output("rst_req_addr", imem_req_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_output("first_req_valid", 32'(imem_req_valid), 32'd1);
    check_output("first_req_addr", imem_req_addr, 32'h0);
    tick();

    // Streaming fetch
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("stream_valid", 32'(imem_req_valid), 32'd1);
      check_output("stream_addr", imem_req_addr, 32'(4 * i));
      expect_inst(32'(4 * i));
      tick();
    end
    imem_req_ready = 1'b0;
    drain("stream_drain");

    // Decode backpressure fills the credit window
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    fires = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req_valid) fires++;
      tick();
    end
    check_output("bp_fires", 32'(fires), 32'd4);
    @(negedge clk);
    check_output("bp_req_blocked", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 5; i++) expect_inst(32'h20 + 32'(4 * i));
    tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    fires = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req_valid) fires++;
      tick();
    end
    check_output("bp_refill_fires", 32'(fires), 32'd1);
    imem_req_ready = 1'b0;
    inst_ready     = 1'b1;
    drain("bp_drain");

    // Flush with two requests in flight
    mem_hold = 1'b1;
    apply_stimulus_redirect(32'h8);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("flush_old_addr", imem_req_addr, 32'h8 + 32'(4 * i));
      tick();
    end
    imem_req_ready = 1'b0;
    apply_stimulus_redirect(32'h100);
    @(negedge clk);
    check_output("flush_new_addr", imem_req_addr, 32'h100);
    tick();
    mem_hold       = 1'b0;
    imem_req_ready = 1'b1;
    expect_inst(32'h100);
    expect_inst(32'h104);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("flush_fetch_addr", imem_req_addr, 32'h100 + 32'(4 * i));
      tick();
    end
    imem_req_ready = 1'b0;
    drain("flush_drain");

    // Alignment and address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    @(negedge clk);
    check_output("redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_output("align_addr", imem_req_addr, 32'h100);
    tick();
    apply_stimulus_redirect(32'hFFFF_FFFC);
    expect_inst(32'hFFFF_FFFC);
    expect_inst(32'h0);
    imem_req_ready = 1'b1;
    @(negedge clk);
    check_output("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check_output("wrap_addr1", imem_req_addr, 32'h0);
    tick();
    imem_req_ready = 1'b0;
    drain("wrap_drain");

    // Memory stall holds the request steady
    apply_stimulus_redirect(32'h200);
    repeat (5) begin
      @(negedge clk);
      check_output("stall_valid", 32'(imem_req_valid), 32'd1);
      check_output("stall_addr", imem_req_addr, 32'h200);
      tick();
    end
    imem_req_ready = 1'b1;
    expect_inst(32'h200);
    tick();
    imem_req_ready = 1'b0;
    drain("stall_drain");

    // Mid-run reset with three buffered and one in flight
    inst_ready = 1'b0;
    apply_stimulus_redirect(32'h300);
    imem_req_ready = 1'b1;
    repeat (3) tick();
    imem_req_ready = 1'b0;
    repeat (2) tick();
    mem_hold       = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    @(negedge clk);
    check_output("pre_rst_inst_valid", 32'(inst_valid), 32'd1);
    check_output("pre_rst_req_blocked", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_inst_valid", 32'(inst_valid), 32'd0);
    check_output("async_req_valid", 32'(imem_req_valid), 32'd0);
    check_output("async_req_addr", imem_req_addr, 32'h0);
    check_output("async_inst_pc", inst_pc, 32'h0);
    tick();
    rst_n      = 1'b1;
    mem_hold   = 1'b0;
    inst_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("late_rsp_inst_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    @(negedge clk);
    check_output("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check_output("post_rst_req_addr", imem_req_addr, 32'h0);
    tick();
    expect_inst(32'h0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    drain("post_rst_drain");

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
